// File: rtl/gelato_warp_fetch_arbiter.sv
// Round-robin warp fetch arbiter: picks one eligible warp per cycle for instruction fetch,
// gated by per-warp instruction-buffer credits and a single outstanding fetch per warp.
module gelato_warp_fetch_arbiter #(
    parameter int NUM_WARPS  = 4,
    parameter int PC_W       = 32,
    parameter int IBUF_DEPTH = 2,
    parameter int WID_W      = $clog2(NUM_WARPS),
    parameter int CRD_W      = $clog2(IBUF_DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rdy_i,
    input  logic [NUM_WARPS-1:0]      warp_active_i,
    input  logic [NUM_WARPS*PC_W-1:0] warp_pc_i,
    output logic                      fetch_valid_o,
    input  logic                      fetch_ready_i,
    output logic [WID_W-1:0]          fetch_warp_o,
    output logic [PC_W-1:0]           fetch_pc_o,
    input  logic                      done_valid_i,
    input  logic [WID_W-1:0]          done_warp_i,
    input  logic                      pop_valid_i,
    input  logic [WID_W-1:0]          pop_warp_i,
    output logic                      err_credit_o
);

    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(IBUF_DEPTH);

    logic [CRD_W-1:0]     credit_q [NUM_WARPS];
    logic [CRD_W-1:0]     credit_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] inflight_q, inflight_d;
    logic [NUM_WARPS-1:0] eligible, crd_ovf;
    logic [PC_W-1:0]      pc_arr [NUM_WARPS];

    logic [WID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 fetch_valid_q, fetch_valid_d;
    logic [WID_W-1:0]     fetch_warp_q, fetch_warp_d;
    logic [PC_W-1:0]      fetch_pc_q, fetch_pc_d;
    logic                 err_q, err_d;

    logic                 hs, load, done_err;
    logic                 sel_any;
    logic [WID_W-1:0]     sel_warp, scan_idx;

    assign hs = fetch_valid_q & fetch_ready_i & rdy_i;

    // A warp being handshaked this cycle is excluded so it cannot be re-granted
    // before its inflight bit becomes visible.
    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
        logic hs_hit, pop_hit, done_hit;

        assign pc_arr[gi] = warp_pc_i[gi*PC_W +: PC_W];
        assign hs_hit     = hs & (fetch_warp_q == WID_W'(gi));
        assign pop_hit    = pop_valid_i & (pop_warp_i == WID_W'(gi));
        assign done_hit   = done_valid_i & (done_warp_i == WID_W'(gi));

        assign eligible[gi] = warp_active_i[gi] & (credit_q[gi] != '0)
                            & ~inflight_q[gi] & ~hs_hit;

        assign crd_ovf[gi]  = pop_hit & ~hs_hit & (credit_q[gi] == CRD_MAX);
        assign credit_d[gi] = (pop_hit & ~hs_hit & ~crd_ovf[gi]) ? credit_q[gi] + CRD_W'(1) :
                              (hs_hit & ~pop_hit)               ? credit_q[gi] - CRD_W'(1) :
                                                                   credit_q[gi];
        // A done in the same cycle as a new grant belongs to the previous fetch.
        assign inflight_d[gi] = hs_hit | (inflight_q[gi] & ~done_hit);
    end

    assign done_err = done_valid_i & ~inflight_q[done_warp_i];
    assign err_d    = err_q | done_err | (|crd_ovf);

    // Scan from the farthest offset down so the closest eligible warp to rr_ptr wins.
    always_comb begin
        sel_any  = 1'b0;
        sel_warp = '0;
        scan_idx = '0;
        for (int k = NUM_WARPS - 1; k >= 0; k--) begin
            scan_idx = rr_ptr_q + WID_W'(k);
            if (eligible[scan_idx]) begin
                sel_any  = 1'b1;
                sel_warp = scan_idx;
            end
        end
    end

    assign load = ~fetch_valid_q | hs;

    always_comb begin
        fetch_valid_d = fetch_valid_q;
        fetch_warp_d  = fetch_warp_q;
        fetch_pc_d    = fetch_pc_q;
        rr_ptr_d      = rr_ptr_q;
        if (load) begin
            fetch_valid_d = sel_any;
            fetch_warp_d  = sel_warp;
            fetch_pc_d    = pc_arr[sel_warp];
            if (sel_any) begin
                rr_ptr_d = sel_warp + WID_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                credit_q[i] <= CRD_MAX;
            end
            inflight_q    <= '0;
            rr_ptr_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_warp_q  <= '0;
            fetch_pc_q    <= '0;
            err_q         <= 1'b0;
        end else if (rdy_i) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                credit_q[i] <= credit_d[i];
            end
            inflight_q    <= inflight_d;
            rr_ptr_q      <= rr_ptr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_warp_q  <= fetch_warp_d;
            fetch_pc_q    <= fetch_pc_d;
            err_q         <= err_d;
        end
    end

    assign fetch_valid_o = fetch_valid_q;
    assign fetch_warp_o  = fetch_warp_q;
    assign fetch_pc_o    = fetch_pc_q;
    assign err_credit_o  = err_q;

endmodule

// File: doc/gelato_warp_fetch_arbiter.md
# gelato_warp_fetch_arbiter

Round-robin fetch arbiter that selects, each cycle, one warp whose PC is sent to the instruction fetch unit. It sits between the split/PC table, which supplies per-warp PCs and active flags, and the instruction fetch stage. It tracks per-warp instruction-buffer credits and a one-outstanding-fetch-per-warp rule so the shared fetch/L1 instruction-cache path is never oversubscribed.

## Interface
- NUM_WARPS, 4: number of warps arbitrated (power of two, ≥2)
- PC_W, 32: PC width
- IBUF_DEPTH, 2: instruction-buffer slots per warp (initial credits)
- WID_W, $clog2(NUM_WARPS): warp id width (derived)
- CRD_W, $clog2(IBUF_DEPTH+1): credit counter width (derived)

- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- rdy  in  1  global enable; when low all state and outputs hold
- warp_active  in  NUM_WARPS  warp eligible for fetch (from PC table)
- warp_pc  in  NUM_WARPS*PC_W  current PC per warp, warp i at bits [i*PC_W +: PC_W]
- fetch_valid  out  1  fetch request valid
- fetch_ready  in  1  fetch unit accepts request
- fetch_warp  out  WID_W  granted warp
- fetch_pc  out  PC_W  PC of granted warp
- done_valid  in  1  fetch of done_warp completed (decoded instruction written)
- done_warp  in  WID_W  warp whose fetch completed
- pop_valid  in  1  instruction buffer freed one slot
- pop_warp  in  WID_W  warp whose slot was freed
- err_credit  out  1  sticky: credit overflow or done without in-flight fetch

## Operation
- Per-warp state: credit[i] (CRD_W bits), inflight[i] (1 bit). Global: rr_ptr (WID_W), output register {fetch_valid, fetch_warp, fetch_pc}.
- Handshake: hs = fetch_valid & fetch_ready & rdy.
- Eligible[i] = warp_active[i] & credit[i]≠0 & ~inflight[i] & ~(hs & fetch_warp==i).
- Selection: first eligible warp scanning rr_ptr, rr_ptr+1, … modulo NUM_WARPS (wraps past NUM_WARPS-1 to 0).
- Output register load: when fetch_valid==0 or hs, load fetch_valid=|eligible, fetch_warp=selected, fetch_pc=warp_pc[selected]; on load with a grant, rr_ptr = selected+1 (mod NUM_WARPS). Otherwise hold.
- Valid/ready rule: once fetch_valid is 1, fetch_warp/fetch_pc stay stable until hs, even if warp_active drops for that warp.
- On hs: inflight[fetch_warp]←1, credit[fetch_warp] decrements.
- On done_valid: inflight[done_warp]←0. If inflight was already 0, set err_credit; state unchanged.
- On pop_valid: credit[pop_warp] increments; if already IBUF_DEPTH, saturate and set err_credit.
- Same-cycle hs and pop on same warp: credit unchanged. Same-cycle hs and done on same warp: inflight ends 1 (set wins; done refers to the previous fetch).
- Reset (rst_n==0 at clk edge, regardless of rdy): credit[i]=IBUF_DEPTH, inflight=0, rr_ptr=0, fetch_valid=0, fetch_warp=0, fetch_pc=0, err_credit=0. A pending request is dropped; reset mid-operation discards all in-flight tracking.
- rdy==0: no register updates; hs is forced 0; done/pop inputs in those cycles are ignored (upstream holds them).

## Timing
- Latency: warp becomes eligible in cycle N → fetch_valid=1 at N+1.
- Back-to-back: with fetch_ready held 1, a new grant (different warp) every cycle; same warp re-granted no earlier than the cycle after its done_valid, provided credit≠0.
- done_valid at N → warp eligible for selection in N+1 → fetch_valid for it at N+2 earliest.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then warp_active=4'b1111, fetch_ready=1, done_valid returned 1 cycle after each hs: grants in order 0,1,2,3,0,… with fetch_pc matching warp_pc, one per cycle after first.
- fetch_ready=0 for 5 cycles with warp 2 granted, then warp_active[2] dropped: fetch_warp=2 and fetch_pc held stable until fetch_ready=1; hs completes for warp 2.
- IBUF_DEPTH=2, only warp 1 active, no pops: exactly 2 fetches accepted, then fetch_valid=0; one pop_valid for warp 1 → fetch_valid=1 two cycles later.
- Same-cycle hs and pop_valid on warp 0 with credit=1: credit stays 1; warp 0 still eligible after its done.
- pop_valid on warp 3 at credit=2 and done_valid on a non-inflight warp: err_credit=1 sticky, credit stays 2; rst_n low one cycle clears err_credit and restores credit=2, fetch_valid=0.
- rdy=0 for 3 cycles mid-stream: all outputs and rr_ptr frozen; sequence resumes unchanged when rdy=1.
